// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with NRD combinational reads, two prioritised writes and a busy scoreboard.
// Optional same-cycle write forwarding on the read ports is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD = 2,
    localparam int AW = $clog2(NREG)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                WE_A,
    input  logic [AW-1:0]       WA_A,
    input  logic [XLEN-1:0]     WD_A,
    input  logic                WE_B,
    input  logic [AW-1:0]       WA_B,
    input  logic [XLEN-1:0]     WD_B,
    input  logic [NRD*AW-1:0]   RA,
    output logic [NRD*XLEN-1:0] RD,
    input  logic                ISSUE_EN,
    input  logic [AW-1:0]       ISSUE_ADDR,
    output logic [NRD-1:0]      BUSY,
    output logic                BUSY_ANY
);
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic wr_a, wr_b, iss;

    // nothing counts as effective while reset is asserted
    assign wr_a = RST && WE_A && WA_A != '0;
    assign wr_b = RST && WE_B && WA_B != '0;
    assign iss = RST && ISSUE_EN && ISSUE_ADDR != '0;
    assign BUSY_ANY = |busy;

    always_ff @(posedge CLK) begin
        for (int r = 0; r < NREG; r++) begin
            regs[r] <= !RST ? '0 : (wr_a && WA_A == AW'(r)) ? WD_A : (wr_b && WA_B == AW'(r)) ? WD_B : regs[r];
            // a new producer's set outranks a completing write's clear
            busy[r] <= RST && r != 0 && ((iss && ISSUE_ADDR == AW'(r)) ||
                       (busy[r] && !(wr_a && WA_A == AW'(r)) && !(wr_b && WA_B == AW'(r))));
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = RA[k*AW +: AW];
`ifdef REGFILE_MP_BYPASS_EN
        logic hit_a, hit_b, hit_i;
        assign hit_a = wr_a && WA_A == ra;
        assign hit_b = wr_b && WA_B == ra;
        assign hit_i = iss && ISSUE_ADDR == ra;
        assign RD[k*XLEN +: XLEN] = (ra == '0) ? '0 : hit_a ? WD_A : hit_b ? WD_B : regs[ra];
        assign BUSY[k] = ra != '0 && busy[ra] && !((hit_a || hit_b) && !hit_i);
`else
        assign RD[k*XLEN +: XLEN] = (ra == '0) ? '0 : regs[ra];
        assign BUSY[k] = ra != '0 && busy[ra];
`endif
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table vectors, directed corner sequences and a randomised model check for regfile_mp.
module tb_regfile_mp;
    logic        CLK = 0;
    logic        RST;
    logic        WE_A, WE_B, ISSUE_EN;
    logic [4:0]  WA_A, WA_B, ISSUE_ADDR;
    logic [31:0] WD_A, WD_B;
    logic [9:0]  RA;
    logic [63:0] RD;
    logic [1:0]  BUSY;
    logic        BUSY_ANY;

    logic        p_we_a;
    logic [3:0]  p_wa_a;
    logic [63:0] p_wd_a;
    logic [11:0] p_ra;
    logic [191:0] p_rd;
    logic [2:0]  p_busy;
    logic        p_busy_any;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    regfile_mp dut (
        .CLK(CLK), .RST(RST),
        .WE_A(WE_A), .WA_A(WA_A), .WD_A(WD_A),
        .WE_B(WE_B), .WA_B(WA_B), .WD_B(WD_B),
        .RA(RA), .RD(RD),
        .ISSUE_EN(ISSUE_EN), .ISSUE_ADDR(ISSUE_ADDR),
        .BUSY(BUSY), .BUSY_ANY(BUSY_ANY)
    );

    regfile_mp #(.XLEN(64), .NREG(16), .NRD(3)) dut_p (
        .CLK(CLK), .RST(RST),
        .WE_A(p_we_a), .WA_A(p_wa_a), .WD_A(p_wd_a),
        .WE_B(1'b0), .WA_B(4'd0), .WD_B(64'd0),
        .RA(p_ra), .RD(p_rd),
        .ISSUE_EN(1'b0), .ISSUE_ADDR(4'd0),
        .BUSY(p_busy), .BUSY_ANY(p_busy_any)
    );

    typedef struct {
        logic rst;
        logic we_a; logic [4:0] wa_a; logic [31:0] wd_a;
        logic we_b; logic [4:0] wa_b; logic [31:0] wd_b;
        logic iss;  logic [4:0] ia;
        logic [4:0] ra0; logic [4:0] ra1;
        logic [31:0] e0; logic [31:0] e1;
        logic b0; logic b1; logic any;
    } vec_t;

    vec_t tbl [10];

    // reference state: plain arrays updated from the architectural rules
    logic [31:0] mem [32];
    bit          bsy [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        RST = 1; WE_A = 0; WE_B = 0; ISSUE_EN = 0;
        WA_A = 0; WA_B = 0; WD_A = 0; WD_B = 0; ISSUE_ADDR = 0;
    endtask

    task automatic apply_vec(input vec_t v, input int i);
        RST = v.rst;
        WE_A = v.we_a; WA_A = v.wa_a; WD_A = v.wd_a;
        WE_B = v.we_b; WA_B = v.wa_b; WD_B = v.wd_b;
        ISSUE_EN = v.iss; ISSUE_ADDR = v.ia;
        @(posedge CLK); #1;
        idle();
        RA = {v.ra1, v.ra0};
        #1;
        chk($sformatf("vec%0d rd0", i), RD[31:0], v.e0);
        chk($sformatf("vec%0d rd1", i), RD[63:32], v.e1);
        chk($sformatf("vec%0d busy0", i), BUSY[0], v.b0);
        chk($sformatf("vec%0d busy1", i), BUSY[1], v.b1);
        chk($sformatf("vec%0d busy_any", i), BUSY_ANY, v.any);
        @(posedge CLK); #1;
    endtask

    function automatic logic eff(input logic rst, input logic en, input logic [4:0] a);
        return rst && en && a != 0;
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 0) return 0;
`ifdef REGFILE_MP_BYPASS_EN
        if (eff(RST, WE_A, WA_A) && WA_A == a) return WD_A;
        if (eff(RST, WE_B, WA_B) && WA_B == a) return WD_B;
`endif
        return mem[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        if (a == 0) return 0;
`ifdef REGFILE_MP_BYPASS_EN
        if (((eff(RST, WE_A, WA_A) && WA_A == a) || (eff(RST, WE_B, WA_B) && WA_B == a)) &&
            !(eff(RST, ISSUE_EN, ISSUE_ADDR) && ISSUE_ADDR == a)) return 0;
`endif
        return bsy[a];
    endfunction

    task automatic model_edge();
        if (!RST) begin
            for (int r = 0; r < 32; r++) begin mem[r] = 0; bsy[r] = 0; end
        end else begin
            if (eff(RST, WE_B, WA_B)) begin mem[WA_B] = WD_B; bsy[WA_B] = 0; end
            if (eff(RST, WE_A, WA_A)) begin mem[WA_A] = WD_A; bsy[WA_A] = 0; end
            if (eff(RST, ISSUE_EN, ISSUE_ADDR)) bsy[ISSUE_ADDR] = 1;
        end
    endtask

    initial begin
        logic any_exp;
        tbl[0] = '{1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 7, 5, 7, 32'hDEADBEEF, 0, 0, 1, 1};
        tbl[1] = '{0, 1, 5, 32'h11111111, 0, 0, 0, 1, 5, 5, 7, 0, 0, 0, 0, 0};
        tbl[2] = '{1, 1, 0, 32'h12345678, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3] = '{1, 1, 3, 32'hAAAA0000, 1, 4, 32'h0000BBBB, 0, 0, 3, 4, 32'hAAAA0000, 32'h0000BBBB, 0, 0, 0};
        tbl[4] = '{1, 1, 9, 32'h1, 1, 9, 32'h2, 0, 0, 9, 3, 32'h1, 32'hAAAA0000, 0, 0, 0};
        tbl[5] = '{1, 0, 0, 0, 0, 0, 0, 1, 10, 10, 9, 0, 32'h1, 1, 0, 1};
        tbl[6] = '{1, 0, 0, 0, 1, 10, 32'h55, 0, 0, 10, 9, 32'h55, 32'h1, 0, 0, 0};
        tbl[7] = '{1, 1, 11, 32'h77, 0, 0, 0, 1, 11, 11, 10, 32'h77, 32'h55, 1, 0, 1};
        tbl[8] = '{1, 0, 0, 0, 1, 11, 32'h88, 1, 12, 11, 12, 32'h88, 0, 0, 1, 1};
        tbl[9] = '{1, 1, 12, 32'h1, 1, 0, 32'h5, 0, 0, 12, 0, 32'h1, 0, 0, 0, 0};

        idle();
        RST = 0; RA = {5'd7, 5'd5};
        p_we_a = 0; p_wa_a = 0; p_wd_a = 0; p_ra = 0;
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1; #1;
        chk("reset rd0", RD[31:0], 0);
        chk("reset rd1", RD[63:32], 0);
        chk("reset busy", BUSY, 0);
        chk("reset busy_any", BUSY_ANY, 0);

        for (int i = 0; i < 10; i++) apply_vec(tbl[i], i);

        // read-during-write on x6
        WE_A = 1; WA_A = 6; WD_A = 32'h10;
        @(posedge CLK); #1;
        WD_A = 32'h20; RA = {5'd0, 5'd6}; #1;
`ifdef REGFILE_MP_BYPASS_EN
        chk("rdw same cycle", RD[31:0], 32'h20);
`else
        chk("rdw same cycle", RD[31:0], 32'h10);
`endif
        @(posedge CLK); #1;
        idle(); #1;
        chk("rdw next cycle", RD[31:0], 32'h20);

        // busy visibility when completing write and reader share a cycle
        ISSUE_EN = 1; ISSUE_ADDR = 13;
        @(posedge CLK); #1;
        idle(); WE_B = 1; WA_B = 13; WD_B = 32'h99; RA = {5'd13, 5'd13}; #1;
`ifdef REGFILE_MP_BYPASS_EN
        chk("clear-bypass busy", BUSY[0], 0);
`else
        chk("clear-bypass busy", BUSY[0], 1);
`endif
        chk("clear-bypass any", BUSY_ANY, 1);
        ISSUE_EN = 1; ISSUE_ADDR = 13; #1;
        chk("clear+issue busy", BUSY[1], 1);
        @(posedge CLK); #1;
        idle(); #1;
        chk("clear+issue after", BUSY[1], 1);
        chk("clear+issue data", RD[63:32], 32'h99);

        // wide/deep variant
        p_we_a = 1; p_wa_a = 15; p_wd_a = 64'hFFFF_FFFF_0000_0001;
        @(posedge CLK); #1;
        p_we_a = 0; p_ra = {4'd15, 4'd15, 4'd15}; #1;
        for (int k = 0; k < 3; k++) chk($sformatf("sweep port%0d", k), p_rd[k*64 +: 64], 64'hFFFF_FFFF_0000_0001);
        p_ra = {4'd15, 4'd15, 4'd0}; #1;
        chk("sweep x0", p_rd[63:0], 0);
        chk("sweep busy", {p_busy_any, p_busy}, 0);

        // random phase starts from a known reset state
        RST = 0;
        @(posedge CLK); #1;
        model_edge();
        idle();
        for (int c = 0; c < 400; c++) begin
            RST = ($urandom_range(0, 59) != 0);
            WE_A = $urandom_range(0, 1); WA_A = 5'($urandom_range(0, 7)); WD_A = $urandom;
            WE_B = $urandom_range(0, 1); WA_B = 5'($urandom_range(0, 7)); WD_B = $urandom;
            ISSUE_EN = $urandom_range(0, 1); ISSUE_ADDR = 5'($urandom_range(0, 7));
            RA = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            #1;
            chk("rand rd0", RD[31:0], m_rd(RA[4:0]));
            chk("rand rd1", RD[63:32], m_rd(RA[9:5]));
            chk("rand busy", BUSY, {m_busy(RA[9:5]), m_busy(RA[4:0])});
            any_exp = 0;
            for (int r = 0; r < 32; r++) any_exp |= bsy[r];
            chk("rand busy_any", BUSY_ANY, any_exp);
            @(posedge CLK);
            model_edge();
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
